// File: rtl/sync_ram_pkg.sv
// Shared helpers for the synchronous RAM primitives: address width, byte merge, byte parity.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// merge_be/byte_par work on a fixed MAX_W-bit container so every RAM width can share them.
// Callers zero-extend into the container and truncate the result back to their own width.
package sync_ram_pkg;

    localparam int MAX_W = 256;
    localparam int MAX_B = MAX_W / 8;

    typedef enum logic {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_init_state_e;

    // Address width for a DEPTH-word array; never returns less than one bit.
    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Byte i of the result comes from new_w when be[i]=1, otherwise from old_w.
    function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int b = 0; b < MAX_B; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Even parity per byte: bit i makes byte i plus its parity bit hold an even number of ones.
    function automatic logic [MAX_B-1:0] byte_par(input logic [MAX_W-1:0] w);
        logic [MAX_B-1:0] p;
        p = '0;
        for (int b = 0; b < MAX_B; b++) begin
            p[b] = ^w[8*b +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// Read-result pipeline: LAT-deep valid/data shift register behind the RAM read port.
// Latency: LAT cycles from in_vld to out_vld.
// Backpressure: none; one result per cycle. A stage keeps its data when its input is invalid.
//
// Ports: clk, rst (sync, active high), in_vld/in_dat (captured read), out_vld/out_dat (result).
module sync_ram_rd_pipe #(
    parameter int LAT = 1,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          out_vld,
    output logic [DW-1:0] out_dat
);

    logic [LAT-1:0] vld_q;
    logic [DW-1:0]  dat_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                dat_q[0] <= in_dat;
            end
            // Later stages move data only behind a valid, so an idle cycle never disturbs rdata.
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/sync_dp_ram.sv
// Single-clock simple dual-port RAM with byte enables, write-first collision forwarding, clear sequencer.
// Latency: read data and rvalid appear RD_LAT (1 or 2) cycles after ren; writes land on the same edge.
// Backpressure: none, except that wen/ren are ignored while init_busy=1 (post-reset clear).
//
// Ports: clk, rst (sync, active high); write port wen/waddr/wdata/wbe; read port ren/raddr;
//        rdata/rvalid read results; init_busy while the clear runs; rd_perr (parity build only).
// Optional: define SYNC_DP_RAM_PARITY_EN to store one even-parity bit per byte and add rd_perr.
module sync_dp_ram
    import sync_ram_pkg::*;
#(
    parameter  int DEPTH        = 16,
    parameter  int WIDTH        = 32,
    parameter  int RD_LAT       = 1,
    parameter  int CLEAR_ON_RST = 1,
    localparam int AW           = addr_w(DEPTH),
    localparam int BW           = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [BW-1:0]    wbe,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             init_busy
`ifdef SYNC_DP_RAM_PARITY_EN
   ,output logic             rd_perr
`endif
);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > MAX_W) begin : g_bad_width
        $error("sync_dp_ram: WIDTH=%0d must be a multiple of 8 between 8 and %0d", WIDTH, MAX_W);
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_dp_ram: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sync_dp_ram: RD_LAT=%0d must be 1 or 2", RD_LAT);
    end

`ifdef SYNC_DP_RAM_PARITY_EN
    localparam int PW = BW;
    localparam int DW = WIDTH + 1;
`else
    localparam int PW = 0;
    localparam int DW = WIDTH;
`endif
    localparam int MW = WIDTH + PW;

    // ---------------- clear sequencer ----------------
    ram_init_state_e state;
    logic [AW-1:0]   clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RST != 0) ? RAM_CLEAR : RAM_IDLE;
            clr_cnt   <= '0;
            init_busy <= (CLEAR_ON_RST != 0);
        end else begin
            case (state)
                RAM_CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state     <= RAM_IDLE;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= RAM_IDLE;
                    init_busy <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- array and write path ----------------
    logic [MW-1:0]    mem [DEPTH];
    logic [WIDTH-1:0] old_dat;
    logic [WIDTH-1:0] mrg_dat;
    logic [MW-1:0]    wr_word;
    logic [MW-1:0]    rd_word;
    logic             wr_go;
    logic             rd_go;

    // An all-zero wbe is dropped entirely so it cannot rewrite (and re-parity) the old word.
    assign wr_go = wen & ~init_busy & (|wbe);
    assign rd_go = ren & ~init_busy;

    assign old_dat = mem[waddr][WIDTH-1:0];
    assign mrg_dat = WIDTH'(merge_be(MAX_W'(old_dat), MAX_W'(wdata), MAX_B'(wbe)));

`ifdef SYNC_DP_RAM_PARITY_EN
    assign wr_word = {PW'(byte_par(MAX_W'(mrg_dat))), mrg_dat};
`else
    assign wr_word = mrg_dat;
`endif

    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_go) begin
            mem[waddr] <= wr_word;
        end
    end

    // Write-first: a same-edge write to the read address returns the merged word being stored.
    assign rd_word = (wr_go && (waddr == raddr)) ? wr_word : mem[raddr];

    // ---------------- read pipeline ----------------
    logic [DW-1:0] pipe_in;
    logic [DW-1:0] pipe_out;

`ifdef SYNC_DP_RAM_PARITY_EN
    logic rd_bad;
    assign rd_bad  = |(rd_word[MW-1:WIDTH] ^ PW'(byte_par(MAX_W'(rd_word[WIDTH-1:0]))));
    assign pipe_in = {rd_bad, rd_word[WIDTH-1:0]};
    assign rdata   = pipe_out[WIDTH-1:0];
    assign rd_perr = pipe_out[WIDTH] & rvalid;
`else
    assign pipe_in = rd_word;
    assign rdata   = pipe_out;
`endif

    sync_ram_rd_pipe #(
        .LAT (RD_LAT),
        .DW  (DW)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_go),
        .in_dat  (pipe_in),
        .out_vld (rvalid),
        .out_dat (pipe_out)
    );

endmodule

// File: tb/tb_sync_dp_ram.sv
// Bench for sync_dp_ram: one RD_LAT=1 and one RD_LAT=2 instance driven by identical stimulus.
// Expected results come from a word-level memory model plus a history of captured reads.
module tb_sync_dp_ram;

    logic        clk = 1'b0;
    logic        rst, wen, ren;
    logic [3:0]  waddr, raddr, wbe;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2, busy1, busy2;
`ifdef SYNC_DP_RAM_PARITY_EN
    logic        perr1, perr2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_dp_ram #(.DEPTH(16), .WIDTH(32), .RD_LAT(1), .CLEAR_ON_RST(1)) u_d1 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .init_busy(busy1)
`ifdef SYNC_DP_RAM_PARITY_EN
       ,.rd_perr(perr1)
`endif
    );

    sync_dp_ram #(.DEPTH(16), .WIDTH(32), .RD_LAT(2), .CLEAR_ON_RST(1)) u_d2 (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .init_busy(busy2)
`ifdef SYNC_DP_RAM_PARITY_EN
       ,.rd_perr(perr2)
`endif
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [16];
    bit          m_bad [16];
    bit          m_busy;
    int          m_clr_left;
    bit          cap_v [$];
    logic [31:0] cap_d [$];
    bit          cap_p [$];
    bit          ev1, ev2, ep1, ep2;
    logic [31:0] ed1, ed2;

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_edge();
        bit          cv;
        logic [31:0] cd;
        bit          cp;
        cv = 1'b0;
        cd = '0;
        cp = 1'b0;
        if (rst) begin
            m_busy     = 1'b1;
            m_clr_left = 16;
            cap_v.delete();
            cap_d.delete();
            cap_p.delete();
            ev1 = 0; ev2 = 0; ep1 = 0; ep2 = 0;
            ed1 = '0; ed2 = '0;
            return;
        end
        if (m_busy) begin
            m_mem[16 - m_clr_left] = '0;
            m_bad[16 - m_clr_left] = 1'b0;
            m_clr_left--;
            if (m_clr_left == 0) m_busy = 1'b0;
        end else begin
            if (wen && wbe != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
                m_bad[waddr] = 1'b0;
            end
            if (ren) begin
                cv = 1'b1;
                cd = m_mem[raddr];
                cp = m_bad[raddr];
            end
        end
        cap_v.push_back(cv);
        cap_d.push_back(cd);
        cap_p.push_back(cp);
        if (cap_v.size() > 2) begin
            void'(cap_v.pop_front());
            void'(cap_d.pop_front());
            void'(cap_p.pop_front());
        end
        ev1 = cv;
        ep1 = cv && cp;
        if (cv) ed1 = cd;
        ev2 = (cap_v.size() == 2) ? cap_v[0] : 1'b0;
        ep2 = ev2 && cap_p[0];
        if (ev2) ed2 = cap_d[0];
    endtask

    task automatic step(input bit w, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input bit r, input logic [3:0] ra);
        wen = w; waddr = wa; wdata = wd; wbe = be; ren = r; raddr = ra;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle();
        n_cmp++;
        if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rvalid got=%b/%b exp=0/0", rvalid1, rvalid2);
        end
        n_cmp++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata got=%h/%h exp=0", rdata1, rdata2);
        end
        n_cmp++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy got=%b/%b exp=1/1", busy1, busy2);
        end
    endtask

    task automatic test_clear();
        int cnt;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && busy1; i++) begin
            idle();
            cnt++;
        end
        n_cmp++;
        if (cnt !== 16 || busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_len got=%0d busy2=%b exp=16 busy2=0", cnt, busy2);
        end
    endtask

    task automatic test_clear_reads();
        for (int a = 0; a < 16; a++) begin
            step(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
            n_cmp++;
            if (rvalid1 !== 1'b1 || rdata1 !== 32'h0 || ed1 !== 32'h0) begin
                n_bad++;
                $display("FAIL clear_read a=%0d got v=%b d=%h exp v=1 d=0", a, rvalid1, rdata1);
            end
        end
        idle();
        n_cmp++;
        if (rvalid2 !== 1'b1 || rdata2 !== 32'h0) begin
            n_bad++;
            $display("FAIL clear_read_lat2 got v=%b d=%h exp v=1 d=0", rvalid2, rdata2);
        end
    endtask

    task automatic test_byte_enable();
        step(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 4'd0);
        step(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
        n_cmp++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'hAA22CC44) begin
            n_bad++;
            $display("FAIL byte_en_lat1 got v=%b d=%h exp v=1 d=aa22cc44", rvalid1, rdata1);
        end
        idle();
        n_cmp++;
        if (rvalid2 !== 1'b1 || rdata2 !== 32'hAA22CC44) begin
            n_bad++;
            $display("FAIL byte_en_lat2 got v=%b d=%h exp v=1 d=aa22cc44", rvalid2, rdata2);
        end
        n_cmp++;
        if (rvalid1 !== 1'b0 || rdata1 !== 32'hAA22CC44) begin
            n_bad++;
            $display("FAIL hold_lat1 got v=%b d=%h exp v=0 d=aa22cc44", rvalid1, rdata1);
        end
    endtask

    task automatic test_collision();
        step(1'b1, 4'd5, 32'h12345678, 4'hF, 1'b0, 4'd0);
        step(1'b1, 4'd5, 32'hFFFFFFFF, 4'b1000, 1'b1, 4'd5);
        n_cmp++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'hFF345678) begin
            n_bad++;
            $display("FAIL collision_lat1 got v=%b d=%h exp v=1 d=ff345678", rvalid1, rdata1);
        end
        idle();
        n_cmp++;
        if (rvalid2 !== 1'b1 || rdata2 !== 32'hFF345678) begin
            n_bad++;
            $display("FAIL collision_lat2 got v=%b d=%h exp v=1 d=ff345678", rvalid2, rdata2);
        end
    endtask

    task automatic test_lat2_stream();
        bit          exp_v [6];
        logic [31:0] exp_d [6];
        exp_v = '{0, 1, 1, 1, 1, 0};
        exp_d = '{32'h0, 32'h10, 32'h11, 32'h12, 32'h13, 32'h13};
        for (int a = 0; a < 4; a++) step(1'b1, 4'(a), 32'h10 + 32'(a), 4'hF, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            // The addr-1 read is captured at k=1; the write to addr 1 lands while it is in flight.
            if (k < 4) step(k == 2, 4'd1, 32'h99, 4'hF, 1'b1, 4'(k));
            else       idle();
            n_cmp++;
            if (rvalid2 !== exp_v[k] || (k > 0 && rdata2 !== exp_d[k])) begin
                n_bad++;
                $display("FAIL stream_lat2 k=%0d got v=%b d=%h exp v=%b d=%h",
                         k, rvalid2, rdata2, exp_v[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] wa;
        for (int i = 0; i < 400; i++) begin
            wa = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
            n_cmp++;
            if (rvalid1 !== ev1 || rdata1 !== ed1) begin
                n_bad++;
                $display("FAIL random_lat1 i=%0d got v=%b d=%h exp v=%b d=%h", i, rvalid1, rdata1, ev1, ed1);
            end
            n_cmp++;
            if (rvalid2 !== ev2 || rdata2 !== ed2) begin
                n_bad++;
                $display("FAIL random_lat2 i=%0d got v=%b d=%h exp v=%b d=%h", i, rvalid2, rdata2, ev2, ed2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) idle();
        rst = 1'b1;
        idle();
        n_cmp++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            n_bad++;
            $display("FAIL midclear_busy got=%b/%b exp=1/1", busy1, busy2);
        end
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && busy1; i++) begin
            idle();
            cnt++;
        end
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL midclear_len got=%0d exp=16", cnt);
        end
        // Reset with a read in flight.
        step(1'b1, 4'd9, 32'hCAFEF00D, 4'hF, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9);
        rst = 1'b1;
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9);
        n_cmp++;
        if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0 || rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_pending got v=%b/%b d=%h/%h exp v=0/0 d=0/0", rvalid1, rvalid2, rdata1, rdata2);
        end
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && busy1; i++) begin
            step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9);
            cnt++;
            n_cmp++;
            if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_ren i=%0d got v=%b/%b exp v=0/0", i, rvalid1, rvalid2);
            end
        end
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL rst_pending_clear_len got=%0d exp=16", cnt);
        end
    endtask

`ifdef SYNC_DP_RAM_PARITY_EN
    task automatic test_parity();
        step(1'b1, 4'd7, 32'h01020304, 4'hF, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
        n_cmp++;
        if (rvalid1 !== 1'b1 || perr1 !== 1'b0 || ep1 !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_clean got v=%b perr=%b exp v=1 perr=0", rvalid1, perr1);
        end
        u_d1.mem[7][0] = ~u_d1.mem[7][0];
        u_d2.mem[7][0] = ~u_d2.mem[7][0];
        m_mem[7][0] = ~m_mem[7][0];
        m_bad[7] = 1'b1;
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
        n_cmp++;
        if (rvalid1 !== 1'b1 || perr1 !== 1'b1 || rdata1 !== 32'h01020305) begin
            n_bad++;
            $display("FAIL parity_err got v=%b perr=%b d=%h exp v=1 perr=1 d=01020305", rvalid1, perr1, rdata1);
        end
        step(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
        n_cmp++;
        if (perr1 !== ep1 || perr2 !== ep2 || perr2 !== 1'b1) begin
            n_bad++;
            $display("FAIL parity_pipe got perr=%b/%b exp perr=%b/%b", perr1, perr2, ep1, ep2);
        end
        idle();
        n_cmp++;
        if (perr1 !== 1'b0 || perr2 !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_idle got perr=%b/%b exp 0/0", perr1, perr2);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wbe = '0;
        test_reset();
        test_clear();
        test_clear_reads();
        test_byte_enable();
        test_collision();
        test_lat2_stream();
        test_random();
        test_reset_mid();
`ifdef SYNC_DP_RAM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
